// File: rtl/block_fifo_pkg.sv
// Shared constants and sizing helper for the block_fifo slice.
package block_fifo_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 256;
    localparam int WIDTH_MAX = 64;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/block_fifo_ram.sv
// Whitebox storage model for block_fifo: DEPTH x WIDTH, one write port,
// one asynchronous read port, no reset.
module block_fifo_ram
    import block_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/block_fifo.sv
// Synchronous valid/ready FIFO with sticky overflow flag.
// Optional macro BLOCK_FIFO_BYPASS_EN adds a zero-latency empty pass-through.
module block_fifo
    import block_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a,
    input  logic                       a_valid,
    output logic                       a_ready,
    output logic [WIDTH-1:0]           o,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] head;
    logic             empty, full, push, pop, pass;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign a_ready = !full && !rst;

`ifdef BLOCK_FIFO_BYPASS_EN
    // An empty FIFO forwards the write word directly when the reader takes it.
    assign pass    = empty && a_valid && o_ready;
    assign o_valid = !empty || a_valid;
    assign o       = empty ? a : head;
`else
    assign pass    = 1'b0;
    assign o_valid = !empty;
    assign o       = empty ? '0 : head;
`endif

    assign push = a_valid && a_ready && !pass;
    assign pop  = !empty && o_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || (a_valid && !a_ready);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    block_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (a),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_block_fifo.sv
// Scoreboard bench for block_fifo (WIDTH=8, DEPTH=4); honours BLOCK_FIFO_BYPASS_EN.
module tb_block_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready;
    logic [2:0] count;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    block_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .o       (o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .count   (count),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One cycle: drive inputs just after the rising edge, then stop at the falling edge.
    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic rdy, input logic acc);
        @(posedge clk);
        #1;
        rst = r; a_valid = v; a = d; o_ready = rdy;
        if (acc) exp_q.push_back(d);
        @(negedge clk);
    endtask

    // Monitor: every read handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no output at %0t", o, $time);
                end else begin
                    chk("sb_data", {24'd0, o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; a_valid = 1'b0; a = 8'h00; o_ready = 1'b0;

        // Reset state
        drive(1, 0, 8'h00, 0, 0);
        drive(1, 0, 8'h00, 0, 0);
        chk("rst_a_ready", {31'd0, a_ready}, 0);
        chk("rst_count",   {29'd0, count},   0);
        chk("rst_o_valid", {31'd0, o_valid}, 0);
        chk("rst_ovf",     {31'd0, ovf},     0);
        chk("rst_o",       {24'd0, o},       0);
        drive(0, 0, 8'h00, 0, 0);
        chk("rel_a_ready", {31'd0, a_ready}, 1);

        // Three pushes, reader stalled
        drive(0, 1, 8'h11, 0, 1);
        drive(0, 1, 8'h22, 0, 1);
        drive(0, 1, 8'h33, 0, 1);
        drive(0, 0, 8'h00, 0, 0);
        chk("p3_count",   {29'd0, count},   3);
        chk("p3_o",       {24'd0, o},       8'h11);
        chk("p3_o_valid", {31'd0, o_valid}, 1);
        chk("p3_a_ready", {31'd0, a_ready}, 1);
        chk("p3_ovf",     {31'd0, ovf},     0);
        repeat (3) drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 0, 0);
        chk("drain_count",   {29'd0, count},   0);
        chk("drain_o_valid", {31'd0, o_valid}, 0);

        // Fill, then overflow attempt
        for (int i = 1; i <= 4; i++) drive(0, 1, 8'(i), 0, 1);
        drive(0, 1, 8'h05, 0, 0);
        chk("full_a_ready", {31'd0, a_ready}, 0);
        chk("full_count",   {29'd0, count},   4);
        chk("full_ovf0",    {31'd0, ovf},     0);
        // Full with a pop in the same cycle: write still refused
        drive(0, 1, 8'h05, 1, 0);
        chk("ovf_set",       {31'd0, ovf},     1);
        chk("fullpop_ready", {31'd0, a_ready}, 0);
        drive(0, 0, 8'h00, 0, 0);
        chk("fullpop_count", {29'd0, count},   3);
        chk("fullpop_o",     {24'd0, o},       8'h02);
        chk("ovf_hold",      {31'd0, ovf},     1);

        // Streaming at count=2 through four pointer wraps
        drive(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 8'(i), 1, 1);
            chk("stream_count", {29'd0, count}, 2);
        end
        drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 0, 0);
        chk("stream_empty", {29'd0, count}, 0);
        chk("stream_o",     {24'd0, o},     0);

        // Mid-operation reset discards contents and in-flight write
        drive(0, 1, 8'h00, 0, 1);
        drive(0, 1, 8'hFF, 0, 1);
        drive(0, 1, 8'h5A, 0, 1);
        drive(1, 1, 8'h77, 0, 0);
        chk("mid_count_pre", {29'd0, count},   3);
        chk("mid_a_ready",   {31'd0, a_ready}, 0);
        exp_q.delete();
        drive(0, 0, 8'h00, 0, 0);
        chk("mid_count",   {29'd0, count},   0);
        chk("mid_o_valid", {31'd0, o_valid}, 0);
        chk("mid_ovf",     {31'd0, ovf},     0);
        chk("mid_o",       {24'd0, o},       0);
        chk("mid_a_ready_up", {31'd0, a_ready}, 1);

        // All-ones / all-zeros ordering after reset
        drive(0, 1, 8'hFF, 0, 1);
        drive(0, 1, 8'h00, 0, 1);
        drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 1, 0);
        drive(0, 0, 8'h00, 0, 0);
        chk("ones_zeros_count", {29'd0, count}, 0);

        // Empty-FIFO write with reader ready
        drive(0, 1, 8'hA5, 1, 1);
`ifdef BLOCK_FIFO_BYPASS_EN
        chk("byp_o_valid", {31'd0, o_valid}, 1);
        chk("byp_o",       {24'd0, o},       8'hA5);
        drive(0, 0, 8'h00, 1, 0);
        chk("byp_count",   {29'd0, count},   0);
        chk("byp_after_valid", {31'd0, o_valid}, 0);
`else
        chk("lat_o_valid0", {31'd0, o_valid}, 0);
        drive(0, 0, 8'h00, 1, 0);
        chk("lat_o_valid1", {31'd0, o_valid}, 1);
        chk("lat_o",        {24'd0, o},       8'hA5);
        drive(0, 0, 8'h00, 0, 0);
        chk("lat_count",    {29'd0, count},   0);
`endif

        drive(0, 0, 8'h00, 0, 0);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/block_fifo.md
BLOCK_FIFO -- requirements
Module: block_fifo

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, 1..64.
- REQ-002 SHALL have parameter DEPTH, default 4: entry count, power of two, 2..256.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge; detected as a clock by name.
- REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port a, input, WIDTH: write data.
- REQ-006 SHALL have port a_valid, input, 1: write request.
- REQ-007 SHALL have port a_ready, output, 1: write accept.
- REQ-008 SHALL have port o, output, WIDTH: read data.
- REQ-009 SHALL have port o_valid, output, 1: read data valid.
- REQ-010 SHALL have port o_ready, input, 1: read accept.
- REQ-011 SHALL have port count, output, $clog2(DEPTH+1): stored entries.
- REQ-012 SHALL have port ovf, output, 1: sticky overflow flag.

Function
- REQ-013 SHALL push a into the tail when a_valid && a_ready at a rising edge.
- REQ-014 SHALL pop the head when o_valid && o_ready at a rising edge.
- REQ-015 SHALL drive a_ready = (count != DEPTH) && !rst.
- REQ-016 SHALL drive o_valid = (count != 0) and o = head entry; o holds its value while o_valid && !o_ready.
- REQ-017 SHALL make a pushed word visible on o/o_valid one cycle after the push edge when the FIFO was empty (latency 1).
- REQ-018 SHALL update count by +1 on push only, -1 on pop only, 0 on simultaneous push and pop.
- REQ-019 SHALL accept simultaneous push and pop when 0 < count < DEPTH, preserving order.
- REQ-020 SHALL refuse a push when full even if a pop occurs in the same cycle (no full pass-through).
- REQ-021 SHALL wrap read and write pointers modulo DEPTH without gaps.
- REQ-022 SHALL set ovf at the edge where a_valid && !a_ready && !rst, holding it until reset.
- REQ-023 SHALL preserve FIFO order for every data pattern, including all-zeros and all-ones words.

Reset
- REQ-024 SHALL, at any edge with rst high, clear pointers, count, ovf and o to 0, giving o_valid=0.
- REQ-025 SHALL hold a_ready low while rst is high and raise it the cycle after rst falls.
- REQ-026 SHALL discard all stored and in-flight words on reset mid-operation; memory contents need not be cleared.

Configuration
- REQ-027 SHALL provide macro BLOCK_FIFO_BYPASS_EN.
- REQ-028 With BLOCK_FIFO_BYPASS_EN defined, SHALL, when count==0, drive o=a and o_valid=a_valid combinationally; a word with a_valid && o_ready passes through unstored, count stays 0, latency 0.
- REQ-029 With BLOCK_FIFO_BYPASS_EN defined and count==0, a_valid && !o_ready SHALL store the word normally.
- REQ-030 Without BLOCK_FIFO_BYPASS_EN, SHALL have no a->o combinational path; REQ-017 latency applies.

Structure
- REQ-031 SHALL place constants DEPTH_MIN, DEPTH_MAX, WIDTH_MAX and a ptr-width helper function in package block_fifo_pkg.
- REQ-032 SHALL instantiate storage as sub-module block_fifo_ram (DEPTH x WIDTH, 1 write port, 1 asynchronous read port, clk only, no reset), annotated whitebox like other simulation models.

Verification (WIDTH=8, DEPTH=4)
- REQ-033 Reset then push 0x11,0x22,0x33 with o_ready=0 -> count=3, o=0x11, o_valid=1, a_ready=1.
- REQ-034 Push 0x01..0x04, then a_valid=1 with 0x05 and o_ready=0 -> a_ready=0, count=4, ovf=1 next cycle and remains 1.
- REQ-035 Full FIFO, a_valid=1, o_ready=1 for one cycle -> 0x01 popped, 0x05 not accepted, count=3.
- REQ-036 Continuous push/pop of 0x00..0x0F at count=2 -> output order 0x00..0x0F, count constant at 2, pointers wrap 4 times.
- REQ-037 rst high for one cycle with count=3 -> next cycle count=0, o_valid=0, ovf=0, o=0x00; a_ready high the cycle after rst falls.
- REQ-038 BLOCK_FIFO_BYPASS_EN: empty, a=0xA5, a_valid=1, o_ready=1 -> o=0xA5, o_valid=1 same cycle, count stays 0; without macro -> o_valid=0 that cycle, o=0xA5 next cycle.
